// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - divider state encodings, funct codes and divide-by-zero constant
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [5:0] EXE_MTHI = 6'b010001;
    localparam logic [5:0] EXE_MTLO = 6'b010011;
    localparam logic [5:0] EXE_DIV  = 6'b011010;
    localparam logic [5:0] EXE_DIVU = 6'b011011;

    localparam logic [63:0] DIV_BYZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // rem < divisor on entry, so the shifted value fits in WIDTH+1 bits and diff's MSB is the borrow
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign ge       = ~diff[WIDTH];
    assign rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle DIV/DIVU unit with HI/LO result; DIV_EARLY_OUT_EN enables |a|<|b| early exit
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, raw_a;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic             neg_q, neg_r, byzero;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign mag_a = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    assign mag_b = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;

    assign stall_o = ((state == DIV_IDLE) && start_i && !annul_i) || (state == DIV_CALC);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            raw_a   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            byzero  <= 1'b0;
            ready_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            ready_o <= 1'b0;
            if (annul_i) begin
                state <= DIV_IDLE;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start_i) begin
                            cnt    <= '0;
                            rem    <= '0;
                            quo    <= mag_a;
                            dvs    <= mag_b;
                            raw_a  <= opa_i;
                            neg_q  <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                            neg_r  <= signed_i & opa_i[WIDTH-1];
                            byzero <= (opb_i == '0);
`ifdef DIV_EARLY_OUT_EN
                            if ((opb_i != '0) && (mag_a < mag_b)) begin
                                // remainder is the dividend itself, already correctly signed
                                state   <= DIV_DONE;
                                ready_o <= 1'b1;
                                lo_o    <= '0;
                                hi_o    <= opa_i;
                            end else begin
                                state <= DIV_CALC;
                            end
`else
                            state <= DIV_CALC;
`endif
                        end
                    end
                    DIV_CALC: begin
                        rem <= rem_n;
                        quo <= quo_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state   <= DIV_DONE;
                            ready_o <= 1'b1;
                            if (byzero) begin
                                lo_o <= DIV_BYZERO_Q[WIDTH-1:0];
                                hi_o <= raw_a;
                            end else begin
                                lo_o <= neg_q ? -quo_n : quo_n;
                                hi_o <= neg_r ? -rem_n : rem_n;
                            end
                        end
                    end
                    DIV_DONE: state <= DIV_IDLE;
                    default:  state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        stall_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .annul_i  (annul_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int bad;
        bad = 0;
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = sgn;
        opa_i    = a;
        opb_i    = b;
        #1;
        check({tag, "_stall_t"}, {31'd0, stall_o}, 32'd1);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            if (ready_o !== (k == lat)) bad++;
            if (stall_o !== (k < lat)) bad++;
        end
        check({tag, "_timing"}, bad, 32'd0);
        check({tag, "_lo"}, lo_o, exp_lo);
        check({tag, "_hi"}, hi_o, exp_hi);
    endtask

    initial begin
        int bad;
        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        annul_i  = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        do_div("div_by0", 1'b1, 32'h1234_5678, 32'd0, 33, 32'hFFFF_FFFF, 32'h1234_5678);
        do_div("divu_by0_big", 1'b0, 32'hF000_0001, 32'd0, 33, 32'hFFFF_FFFF, 32'hF000_0001);
        do_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF, 32'd15);
        do_div("div_wrap", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        do_div("divu_5_9", 1'b0, 32'd5, 32'd9, EARLY_LAT, 32'd0, 32'd5);
        do_div("div_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, EARLY_LAT, 32'd0, 32'hFFFF_FFFD);
        do_div("divu_9_5", 1'b0, 32'd9, 32'd5, 33, 32'd1, 32'd4);
        do_div("div_wrap2", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);

        // annul mid-CALC: result registers keep div_wrap2 values
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = 1'b0;
        opa_i    = 32'd1000;
        opb_i    = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        annul_i = 1'b1;
        #1;
        check("annul_stall_calc", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        check("annul_idle_stall", {31'd0, stall_o}, 32'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || stall_o !== 1'b0) bad++;
        end
        check("annul_no_ready", bad, 32'd0);
        check("annul_lo_kept", lo_o, 32'h8000_0000);
        check("annul_hi_kept", hi_o, 32'd0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

        // async reset between edges in CALC
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = 1'b0;
        opa_i    = 32'd100;
        opb_i    = 32'd7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", {31'd0, ready_o}, 32'd0);
        check("arst_stall", {31'd0, stall_o}, 32'd0);
        check("arst_lo", lo_o, 32'd0);
        check("arst_hi", hi_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0) bad++;
        end
        check("arst_no_ready", bad, 32'd0);
        do_div("divu_after_rst", 1'b0, 32'd1000, 32'd3, 33, 32'd333, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
